// File: rtl/ext_bus_bridge.sv
`default_nettype none
// ============================================================================
// ext_bus_bridge : Avalon-MM slave fanning one window out to NUM_CH
//                  bus_enable/rw/acknowledge channels plus a bridge CSR block.
// Revision       : 1.0
// ============================================================================
module ext_bus_bridge #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 32,
    parameter int NUM_CH  = 5,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [SEL_W+ADDR_W-1:0]    avs_address,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [DATA_W/8-1:0]        avs_byteenable,
    input  logic [DATA_W-1:0]          avs_writedata,
    output logic [DATA_W-1:0]          avs_readdata,
    output logic                       avs_waitrequest,
    output logic [NUM_CH*ADDR_W-1:0]   ch_address,
    output logic [NUM_CH-1:0]          ch_bus_enable,
    output logic [NUM_CH*DATA_W/8-1:0] ch_byte_enable,
    output logic [NUM_CH-1:0]          ch_rw,
    output logic [NUM_CH*DATA_W-1:0]   ch_write_data,
    input  logic [NUM_CH*DATA_W-1:0]   ch_read_data,
    input  logic [NUM_CH-1:0]          ch_acknowledge,
    input  logic [NUM_CH-1:0]          ch_irq,
    output logic                       irq
);

    localparam int               BE_W    = DATA_W / 8;
    localparam int               ERR_W   = NUM_CH + 1;
    localparam logic [SEL_W-1:0] CSR_SEL = SEL_W'(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CSR   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [15:0]         to_q, to_d;
    logic [NUM_CH-1:0]   irq_q;
    logic                irq_out_q;

    logic [SEL_W-1:0]    req_sel;
    logic [NUM_CH-1:0]   hit;
    logic [DATA_W-1:0]   ch_rdata_sel;
    logic                ack_sel;
    logic                to_hit;
    logic [15:0]         csr_word;
    logic [ERR_W-1:0]    err_set;
    logic [ERR_W-1:0]    err_clr;

    assign req_sel = avs_address[SEL_W+ADDR_W-1 -: SEL_W];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign hit[c]                            = (state_q == S_ISSUE) && (sel_q == SEL_W'(c));
        assign ch_bus_enable[c]                  = hit[c];
        assign ch_address[c*ADDR_W +: ADDR_W]    = hit[c] ? addr_q  : '0;
        assign ch_byte_enable[c*BE_W +: BE_W]    = hit[c] ? be_q    : '0;
        assign ch_write_data[c*DATA_W +: DATA_W] = hit[c] ? wdata_q : '0;
        assign ch_rw[c]                          = hit[c] ? rd_q    : 1'b1;
    end

    always_comb begin
        ch_rdata_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit[c]) begin
                ch_rdata_sel = ch_rdata_sel | ch_read_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign ack_sel = |(ch_acknowledge & hit);
    assign to_hit  = (to_q != 16'd0) && (cnt_q == to_q - 16'd1);

    // Only word addresses 0..3 of the CSR window are backed by registers.
    always_comb begin
        csr_word = '0;
        if ((addr_q >> 2) == '0) begin
            case (addr_q[1:0])
                2'd0:    csr_word = 16'(irq_q);
                2'd1:    csr_word = 16'(mask_q);
                2'd2:    csr_word = 16'(err_q);
                default: csr_word = to_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mask_d  = mask_q;
        to_d    = to_q;
        err_set = '0;
        err_clr = '0;

        case (state_q)
            S_IDLE: begin
                if (avs_read || avs_write) begin
                    sel_d   = req_sel;
                    addr_d  = avs_address[ADDR_W-1:0];
                    be_d    = avs_byteenable;
                    wdata_d = avs_writedata;
                    rd_d    = avs_read;
                    cnt_d   = '0;
                    if (req_sel < CSR_SEL) begin
                        state_d = S_ISSUE;
                    end else if (req_sel == CSR_SEL) begin
                        state_d = S_CSR;
                    end else begin
                        err_set[NUM_CH] = 1'b1;
                        rdata_d         = '0;
                        state_d         = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 16'd1;
                // Acknowledge is checked first so it wins over a coincident timeout.
                if (ack_sel) begin
                    if (rd_q) begin
                        rdata_d = ch_rdata_sel;
                    end
                    state_d = S_DONE;
                end else if (to_hit) begin
                    err_set = ERR_W'(hit);
                    if (rd_q) begin
                        rdata_d = '1;
                    end
                    state_d = S_DONE;
                end
            end
            S_CSR: begin
                if (rd_q) begin
                    rdata_d = DATA_W'(csr_word);
                end else if ((addr_q >> 2) == '0) begin
                    case (addr_q[1:0])
                        2'd1:    mask_d  = NUM_CH'(wdata_q);
                        2'd2:    err_clr = ERR_W'(wdata_q);
                        2'd3:    to_d    = 16'(wdata_q);
                        default: ;
                    endcase
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_d = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b1;
            cnt_q     <= '0;
            rdata_q   <= '0;
            mask_q    <= '0;
            err_q     <= '0;
            to_q      <= 16'(TIMEOUT);
            irq_q     <= '0;
            irq_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            to_q      <= to_d;
            irq_q     <= ch_irq;
            irq_out_q <= |(irq_q & mask_q);
        end
    end

    assign avs_readdata    = rdata_q;
    assign avs_waitrequest = (state_q != S_DONE);
    assign irq             = irq_out_q;

endmodule
`default_nettype wire
